// File: rtl/vga_mem_writer.sv
// Write-port feeder for the VGA controller's two line memories: turns a
// command plus a 32-bit word stream into data/wraddress/wren/memorySel.
module vga_mem_writer #(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 32,
  parameter bit VSYNC_GATE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_sel,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [ADDR_W:0]   cmd_len,
  input  logic              word_valid,
  output logic              word_ready,
  input  logic [DATA_W-1:0] word_data,
  input  logic              vsync,
  output logic [DATA_W-1:0] data,
  output logic [ADDR_W-1:0] wraddress,
  output logic              wren,
  output logic              memorySel,
  output logic              busy,
  output logic              done
);

  // state   | meaning
  // IDLE    | ready for a command
  // WAIT_VS | burst latched, holding for a vsync falling edge
  // WRITE   | accepting stream words, one memory write per word
  // DONE    | one-cycle completion pulse
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t r_state;
  state_t w_next;

  logic              r_vs_s1;
  logic              r_vs_s2;
  logic              r_vs_prev;
  logic              w_vs_fall;

  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_remaining;
  logic [ADDR_W:0]   w_len_sat;
  logic              w_xfer;
  logic              w_last;

  logic [DATA_W-1:0] r_data;
  logic [ADDR_W-1:0] r_wraddress;
  logic              r_wren;
  logic              r_mem_sel;

  assign w_vs_fall = r_vs_prev & ~r_vs_s2;
  assign w_len_sat = (cmd_len > DEPTH) ? DEPTH : cmd_len;
  assign w_xfer    = (r_state == WRITE) && word_valid;
  assign w_last    = w_xfer && (r_remaining == LEN_ONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_len == '0) begin
            w_next = DONE;
          end else if (VSYNC_GATE) begin
            w_next = WAIT_VS;
          end else begin
            w_next = WRITE;
          end
        end
      end
      WAIT_VS: begin
        if (w_vs_fall) begin
          w_next = WRITE;
        end
      end
      WRITE: begin
        if (w_last) begin
          w_next = DONE;
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // cmd_ready is masked by rst so it reads 0 while reset is held.
  always_comb begin
    cmd_ready  = (r_state == IDLE) && !rst;
    word_ready = (r_state == WRITE);
    busy       = (r_state == WAIT_VS) || (r_state == WRITE);
    done       = (r_state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vs_s1     <= 1'b1;
      r_vs_s2     <= 1'b1;
      r_vs_prev   <= 1'b1;
      r_addr      <= '0;
      r_remaining <= '0;
      r_data      <= '0;
      r_wraddress <= '0;
      r_wren      <= 1'b0;
      r_mem_sel   <= 1'b0;
    end else begin
      r_vs_s1   <= vsync;
      r_vs_s2   <= r_vs_s1;
      r_vs_prev <= r_vs_s2;
      r_wren    <= 1'b0;
      if ((r_state == IDLE) && cmd_valid) begin
        r_mem_sel   <= cmd_sel;
        r_addr      <= cmd_base;
        r_remaining <= w_len_sat;
      end
      if (w_xfer) begin
        r_data      <= word_data;
        r_wraddress <= r_addr;
        r_wren      <= 1'b1;
        r_addr      <= r_addr + ADDR_ONE;
        r_remaining <= r_remaining - LEN_ONE;
      end
    end
  end

  assign data      = r_data;
  assign wraddress = r_wraddress;
  assign wren      = r_wren;
  assign memorySel = r_mem_sel;

endmodule

// File: tb/tb_vga_mem_writer.sv
// Directed bench for vga_mem_writer: one instance without vsync gating and
// one with it, sharing every input except cmd_valid.
module tb_vga_mem_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid0 = 1'b0;
  logic        cmd_valid1 = 1'b0;
  logic        cmd_sel = 1'b0;
  logic [5:0]  cmd_base = '0;
  logic [6:0]  cmd_len = '0;
  logic        word_valid = 1'b0;
  logic [31:0] word_data = '0;
  logic        vsync = 1'b1;

  logic        cmd_ready0, word_ready0, wren0, memorySel0, busy0, done0;
  logic [31:0] data0;
  logic [5:0]  wraddress0;
  logic        cmd_ready1, word_ready1, wren1, memorySel1, busy1, done1;
  logic [31:0] data1;
  logic [5:0]  wraddress1;

  always #5 clk = ~clk;

  vga_mem_writer #(.ADDR_W(6), .DATA_W(32), .VSYNC_GATE(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0),
    .cmd_sel(cmd_sel), .cmd_base(cmd_base), .cmd_len(cmd_len),
    .word_valid(word_valid), .word_ready(word_ready0), .word_data(word_data),
    .vsync(vsync), .data(data0), .wraddress(wraddress0), .wren(wren0),
    .memorySel(memorySel0), .busy(busy0), .done(done0)
  );

  vga_mem_writer #(.ADDR_W(6), .DATA_W(32), .VSYNC_GATE(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
    .cmd_sel(cmd_sel), .cmd_base(cmd_base), .cmd_len(cmd_len),
    .word_valid(word_valid), .word_ready(word_ready1), .word_data(word_data),
    .vsync(vsync), .data(data1), .wraddress(wraddress1), .wren(wren1),
    .memorySel(memorySel1), .busy(busy1), .done(done1)
  );

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc_n = 0;
  int          excl_viol = 0;
  int          done_cnt = 0;
  bit          mon_sel = 1'b0;
  int          wr_addr[$];
  logic [31:0] wr_data[$];
  bit          wr_msel[$];
  int          wr_cyc[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Write log of the selected instance, sampled on the falling edge.
  always @(negedge clk) begin
    cyc_n++;
    if ((cmd_ready0 && word_ready0) || (cmd_ready1 && word_ready1)) excl_viol++;
    if (mon_sel ? wren1 : wren0) begin
      wr_addr.push_back(int'(mon_sel ? wraddress1 : wraddress0));
      wr_data.push_back(mon_sel ? data1 : data0);
      wr_msel.push_back(mon_sel ? memorySel1 : memorySel0);
      wr_cyc.push_back(cyc_n);
    end
    if (mon_sel ? done1 : done0) done_cnt++;
  end

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_msel.delete();
    wr_cyc.delete();
    done_cnt = 0;
  endtask

  // Called on a falling edge with the target in IDLE; returns one cycle later.
  task automatic send_cmd(input bit which, input bit sel, input logic [5:0] base,
                          input logic [6:0] len);
    cmd_sel  = sel;
    cmd_base = base;
    cmd_len  = len;
    if (which) cmd_valid1 = 1'b1;
    else       cmd_valid0 = 1'b1;
    chk("cmd_ready", which ? cmd_ready1 : cmd_ready0, 1);
    @(negedge clk);
    cmd_valid0 = 1'b0;
    cmd_valid1 = 1'b0;
  endtask

  // Streams n words seed+k; word_valid is held low on burst cycles st_a..st_b.
  task automatic stream(input bit which, input int n, input logic [31:0] seed,
                        input int st_a, input int st_b);
    int sent = 0;
    int cyc = 0;
    while (sent < n && cyc < 300) begin
      word_valid = !(cyc >= st_a && cyc <= st_b);
      word_data  = seed + sent;
      if (word_valid && (which ? word_ready1 : word_ready0)) sent++;
      cyc++;
      @(negedge clk);
    end
    word_valid = 1'b0;
    chk("stream_words_taken", sent, n);
  endtask

  task automatic check_burst(input bit sel, input int base, input int n, input logic [31:0] seed);
    chk("write_count", wr_addr.size(), n);
    chk("done_count", done_cnt, 1);
    foreach (wr_addr[i]) begin
      chk("wraddress", wr_addr[i], (base + i) % 64);
      chk("data", wr_data[i], seed + i);
      chk("memorySel", wr_msel[i], sel);
    end
  endtask

  initial begin
    int k;
    int bad;
    repeat (3) @(negedge clk);
    chk("rst_data", data0, 0);
    chk("rst_wraddress", wraddress0, 0);
    chk("rst_wren", wren0, 0);
    chk("rst_memorySel", memorySel0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_cmd_ready", cmd_ready0, 0);
    chk("rst_word_ready", word_ready0, 0);
    chk("rst_cmd_ready_gated", cmd_ready1, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy0, 0);

    // Back-to-back burst, base 5
    clear_log();
    mon_sel = 1'b0;
    send_cmd(1'b0, 1'b0, 6'd5, 7'd3);
    chk("t1_busy", busy0, 1);
    stream(1'b0, 3, 32'hA000_0000, -1, -1);
    @(negedge clk);
    chk("t1_cmd_ready_back", cmd_ready0, 1);
    @(negedge clk);
    check_burst(1'b0, 5, 3, 32'hA000_0000);
    chk("t1_consecutive", wr_cyc[2] - wr_cyc[0], 2);

    // Address wrap 62,63,0,1 on bank 1
    clear_log();
    send_cmd(1'b0, 1'b1, 6'd62, 7'd4);
    stream(1'b0, 4, 32'hB000_0000, -1, -1);
    repeat (2) @(negedge clk);
    check_burst(1'b1, 62, 4, 32'hB000_0000);

    // Stream stall on burst cycles 2-3
    clear_log();
    send_cmd(1'b0, 1'b0, 6'd10, 7'd4);
    stream(1'b0, 4, 32'hC000_0000, 1, 2);
    repeat (2) @(negedge clk);
    check_burst(1'b0, 10, 4, 32'hC000_0000);
    chk("t3_gap", wr_cyc[1] - wr_cyc[0], 3);
    chk("t3_tail", wr_cyc[3] - wr_cyc[1], 2);

    // Zero length: done pulse only, bank select still updates
    clear_log();
    send_cmd(1'b0, 1'b1, 6'd40, 7'd0);
    repeat (2) @(negedge clk);
    chk("t4_writes", wr_addr.size(), 0);
    chk("t4_done", done_cnt, 1);
    chk("t4_memorySel", memorySel0, 1);
    chk("t4_cmd_ready", cmd_ready0, 1);

    // Length 100 saturates to 64; extra words afterwards are not consumed
    clear_log();
    send_cmd(1'b0, 1'b0, 6'd20, 7'd100);
    stream(1'b0, 64, 32'hD000_0000, -1, -1);
    word_valid = 1'b1;
    repeat (3) @(negedge clk);
    word_valid = 1'b0;
    @(negedge clk);
    check_burst(1'b0, 20, 64, 32'hD000_0000);
    chk("t5_busy", busy0, 0);

    // Reset after 2 of 6 words
    clear_log();
    send_cmd(1'b0, 1'b1, 6'd30, 7'd6);
    stream(1'b0, 2, 32'hE000_0000, -1, -1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_wren", wren0, 0);
    chk("t6_busy", busy0, 0);
    chk("t6_memorySel", memorySel0, 0);
    chk("t6_data", data0, 0);
    chk("t6_word_ready", word_ready0, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_no_done", done_cnt, 0);
    chk("t6_writes", wr_addr.size(), 2);
    clear_log();
    send_cmd(1'b0, 1'b0, 6'd0, 7'd2);
    stream(1'b0, 2, 32'hF000_0000, -1, -1);
    repeat (2) @(negedge clk);
    check_burst(1'b0, 0, 2, 32'hF000_0000);

    // Gated instance holds the burst until a vsync falling edge
    clear_log();
    mon_sel = 1'b1;
    send_cmd(1'b1, 1'b0, 6'd8, 7'd3);
    word_valid = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (word_ready1 || wren1) bad++;
    end
    word_valid = 1'b0;
    chk("t7_hold", bad, 0);
    chk("t7_busy", busy1, 1);
    vsync = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!word_ready1 && k < 20);
    chk("t7_vsync_latency", k, 3);
    stream(1'b1, 3, 32'h1234_0000, -1, -1);
    repeat (2) @(negedge clk);
    check_burst(1'b0, 8, 3, 32'h1234_0000);

    // A vsync fall seen in IDLE is not remembered
    vsync = 1'b1;
    repeat (4) @(negedge clk);
    vsync = 1'b0;
    repeat (4) @(negedge clk);
    clear_log();
    send_cmd(1'b1, 1'b1, 6'd0, 7'd1);
    word_valid = 1'b1;
    repeat (10) @(negedge clk);
    word_valid = 1'b0;
    chk("t8_no_writes", wr_addr.size(), 0);
    chk("t8_word_ready", word_ready1, 0);
    chk("t8_busy", busy1, 1);
    vsync = 1'b1;
    repeat (3) @(negedge clk);
    vsync = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!word_ready1 && k < 20);
    chk("t8_vsync_latency", k, 3);
    stream(1'b1, 1, 32'h5555_0000, -1, -1);
    repeat (2) @(negedge clk);
    check_burst(1'b1, 0, 1, 32'h5555_0000);

    chk("ready_exclusive", excl_viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
